// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 32x32 register file.
// After reset it sweeps registers 1..NREG-1 (zero, except the stack pointer,
// which gets SP_INIT), then shares the single write port between requester
// A (ALU writeback) and requester B (load writeback) in round-robin order.
// Writes that target R0 are consumed without touching the file, and a
// one-cycle r0_drop pulse is raised for each one.
module regfile_wr_sched #(
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int NREG    = 32,
  parameter int SP_ADDR = 29,
  parameter int SP_INIT = 252
) (
  input  logic          elk,
  input  logic          nrst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          init_busy,
  output logic          r0_drop,
  output logic          grant_b
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);
  localparam logic [AW-1:0] SP_A      = AW'(SP_ADDR);
  localparam logic [DW-1:0] SP_VAL    = DW'(SP_INIT);

  state_t        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          rr_ptr_q, rr_ptr_d;   // 0: A favoured on a tie, 1: B favoured
  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [DW-1:0] wr_data_d;
  logic          init_busy_d;
  logic          r0_drop_d;
  logic          grant_b_d;

  logic          is_run;
  logic          any_acc;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Readiness is suppressed while nrst is asserted: the write would be
  // cancelled on that edge, so the requester must keep its request pending.
  assign is_run   = (state_q == RUN);
  assign a_ready  = is_run & ~nrst & a_valid & (~b_valid | ~rr_ptr_q);
  assign b_ready  = is_run & ~nrst & b_valid & (~a_valid |  rr_ptr_q);
  assign any_acc  = a_ready | b_ready;
  assign sel_addr = b_ready ? b_addr : a_addr;
  assign sel_data = b_ready ? b_data : a_data;

  // Next-state and next-output logic for the sweep and the arbiter.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    init_busy_d = init_busy;
    r0_drop_d   = 1'b0;
    grant_b_d   = grant_b;

    case (state_q)
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_ptr_q;
        wr_data_d = (clr_ptr_q == SP_A) ? SP_VAL : '0;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d     = RUN;
          init_busy_d = 1'b0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      RUN: begin
        if (any_acc) begin
          rr_ptr_d  = a_ready;        // hand priority to the other requester
          grant_b_d = b_ready;
          if (sel_addr != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
          end else begin
            r0_drop_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State and registered outputs, with synchronous active-high reset.
  always_ff @(posedge elk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    if (nrst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= AW'(1);
      rr_ptr_q  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_busy <= 1'b1;
      r0_drop   <= 1'b0;
      grant_b   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      init_busy <= init_busy_d;
      r0_drop   <= r0_drop_d;
      grant_b   <= grant_b_d;
    end
  end

endmodule
